// File: rtl/uart_tx_pkg.sv
// Shared UART frame codes, FSM states and helpers for the transmitter.
// Baud divisors and parity are derived here so Rx and Tx agree on them.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    BD_1200 = 2'b00,
    BD_2400 = 2'b01,
    BD_4800 = 2'b10,
    BD_9600 = 2'b11
  } baud_e;

  typedef enum logic [1:0] {
    PRTY_NONE  = 2'b00,
    PRTY_ODD   = 2'b01,
    PRTY_EVEN  = 2'b10,
    PRTY_NONE2 = 2'b11
  } prty_e;

  typedef enum logic {
    DBIT_7 = 1'b0,
    DBIT_8 = 1'b1
  } dbit_e;

  typedef enum logic {
    STOP_1 = 1'b0,
    STOP_2 = 1'b1
  } stop_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  typedef struct packed {
    logic [7:0] data;
    dbit_e      dbit;
    stop_e      stop;
    prty_e      prty;
    baud_e      bd;
  } tx_cfg_t;

  function automatic int unsigned baud_rate(baud_e bd);
    case (bd)
      BD_1200: return 1200;
      BD_2400: return 2400;
      BD_4800: return 4800;
      default: return 9600;
    endcase
  endfunction

  // Rounded integer divide so non-ideal clocks still land on the nearest rate.
  function automatic int unsigned calc_div(int unsigned clk_hz, int unsigned os, baud_e bd);
    int unsigned r;
    r = baud_rate(bd) * os;
    return (clk_hz + r / 2) / r;
  endfunction

  function automatic logic has_parity(prty_e p);
    return (p == PRTY_ODD) || (p == PRTY_EVEN);
  endfunction

  function automatic logic calc_parity(logic [7:0] data, dbit_e dbit, prty_e prty);
    logic [7:0] masked;
    logic       p;
    masked = (dbit == DBIT_8) ? data : {1'b0, data[6:0]};
    p      = ^masked;
    return (prty == PRTY_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-clock tick every DIV clocks for the selected baud.
// clr restarts the count so a new frame begins on a full tick period.
module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 1_843_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] bd_sel,
  output logic       tick
);

  localparam int unsigned DIV_1200 = calc_div(CLK_HZ, OVERSAMPLE, BD_1200);
  localparam int unsigned DIV_2400 = calc_div(CLK_HZ, OVERSAMPLE, BD_2400);
  localparam int unsigned DIV_4800 = calc_div(CLK_HZ, OVERSAMPLE, BD_4800);
  localparam int unsigned DIV_9600 = calc_div(CLK_HZ, OVERSAMPLE, BD_9600);
  localparam int unsigned CW       = (DIV_1200 > 2) ? $clog2(DIV_1200) : 1;

  logic [CW-1:0] div_last;
  logic [CW-1:0] cnt;

  always_comb begin
    div_last = CW'(DIV_9600 - 1);
    case (bd_sel)
      BD_1200: div_last = CW'(DIV_1200 - 1);
      BD_2400: div_last = CW'(DIV_2400 - 1);
      BD_4800: div_last = CW'(DIV_4800 - 1);
      default: div_last = CW'(DIV_9600 - 1);
    endcase
  end

  assign tick = (cnt == div_last);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt >= div_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: latches a byte and frame config on handshake, then
// serialises start/data/parity/stop bits LSB first; line idles high.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 1_843_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in_Tx,
  input  logic       tx_start,
  input  logic       data_bit_sel,
  input  logic       stop_sel,
  input  logic [1:0] prty_sel,
  input  logic [1:0] bd_sel,
  output logic       data_out_Tx,
  output logic       tx_ready,
  output logic       tx_done
);

  localparam int unsigned     TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]   TICK_LAST = TW'(OVERSAMPLE - 1);

  tx_state_e     state;
  tx_cfg_t       cfg;
  logic [2:0]    bit_idx;
  logic [2:0]    last_idx;
  logic [TW-1:0] tick_cnt;
  logic          stop_cnt;
  logic          accept;
  logic          tick;
  logic          bit_end;

  assign accept   = tx_start & tx_ready;
  assign bit_end  = tick & (tick_cnt == TICK_LAST);
  assign last_idx = (cfg.dbit == DBIT_8) ? 3'd7 : 3'd6;

  // Divider runs off the latched rate; it restarts on the accept edge.
  uart_baud_gen #(
    .CLK_HZ     (CLK_HZ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .bd_sel (cfg.bd),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cfg         <= '0;
      bit_idx     <= '0;
      tick_cnt    <= '0;
      stop_cnt    <= 1'b0;
      data_out_Tx <= 1'b1;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (state != ST_IDLE && tick) begin
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            cfg <= '{data: data_in_Tx,
                     dbit: dbit_e'(data_bit_sel),
                     stop: stop_e'(stop_sel),
                     prty: prty_e'(prty_sel),
                     bd:   baud_e'(bd_sel)};
            state       <= ST_START;
            data_out_Tx <= 1'b0;
            tx_ready    <= 1'b0;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            stop_cnt    <= 1'b0;
          end
        end

        ST_START: begin
          if (bit_end) begin
            state       <= ST_DATA;
            bit_idx     <= '0;
            data_out_Tx <= cfg.data[0];
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == last_idx) begin
              if (has_parity(cfg.prty)) begin
                state       <= ST_PARITY;
                data_out_Tx <= calc_parity(cfg.data, cfg.dbit, cfg.prty);
              end else begin
                state       <= ST_STOP;
                data_out_Tx <= 1'b1;
                stop_cnt    <= 1'b0;
              end
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              data_out_Tx <= cfg.data[bit_idx + 3'd1];
            end
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            state       <= ST_STOP;
            data_out_Tx <= 1'b1;
            stop_cnt    <= 1'b0;
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            if (stop_cnt == (cfg.stop == STOP_2)) begin
              state    <= ST_IDLE;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end

        default: begin
          state       <= ST_IDLE;
          data_out_Tx <= 1'b1;
          tx_ready    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level model compared every cycle,
// plus literal frame patterns, back-to-back, ignored-start and reset cases.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in_Tx = '0;
  logic       tx_start = 1'b0;
  logic       data_bit_sel = 1'b0;
  logic       stop_sel = 1'b0;
  logic [1:0] prty_sel = '0;
  logic [1:0] bd_sel = '0;
  logic       data_out_Tx;
  logic       tx_ready;
  logic       tx_done;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_HZ(1_843_200), .OVERSAMPLE(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in_Tx   (data_in_Tx),
    .tx_start     (tx_start),
    .data_bit_sel (data_bit_sel),
    .stop_sel     (stop_sel),
    .prty_sel     (prty_sel),
    .bd_sel       (bd_sel),
    .data_out_Tx  (data_out_Tx),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done)
  );

  // ---------------- frame-level reference model ----------------
  bit          m_bits[12];
  int unsigned m_nbits, m_bitlen, m_cnt;
  bit          m_busy = 0;
  logic        exp_line = 1'b1, exp_ready = 1'b1, exp_done = 1'b0;

  function automatic int unsigned div_of(logic [1:0] bd);
    case (bd)
      2'd0:    return 96;
      2'd1:    return 48;
      2'd2:    return 24;
      default: return 12;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; exp_line = 1'b1; exp_ready = 1'b1; exp_done = 1'b0;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == m_nbits * m_bitlen) begin
        m_busy = 0; exp_line = 1'b1; exp_ready = 1'b1; exp_done = 1'b1;
      end else begin
        exp_line = m_bits[m_cnt / m_bitlen];
      end
    end else begin
      exp_done = 1'b0;
      if (tx_start) begin
        int unsigned n, ones, k;
        n = data_bit_sel ? 8 : 7;
        ones = 0;
        m_bits[0] = 0;
        for (int unsigned i = 0; i < n; i++) begin
          m_bits[1 + i] = data_in_Tx[i];
          ones += data_in_Tx[i];
        end
        k = 1 + n;
        if (prty_sel == 2'b10) begin m_bits[k] = bit'(ones % 2); k++; end
        if (prty_sel == 2'b01) begin m_bits[k] = bit'(1 - ones % 2); k++; end
        for (int unsigned s = 0; s < (stop_sel ? 2 : 1); s++) begin m_bits[k] = 1; k++; end
        m_nbits  = k;
        m_bitlen = 16 * div_of(bd_sel);
        m_cnt    = 0;
        m_busy   = 1;
        exp_line = 1'b0;
        exp_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if ({data_out_Tx, tx_ready, tx_done} !== {exp_line, exp_ready, exp_done}) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t line/ready/done got %b%b%b expected %b%b%b",
                 $time, data_out_Tx, tx_ready, tx_done, exp_line, exp_ready, exp_done);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int i = 0;
    while (!tx_ready && i < 30000) begin step(1); i++; end
    if (!tx_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int i = 0;
    while (!tx_done && i < 30000) begin step(1); i++; end
    check("done_seen", int'(tx_done), 1);
  endtask

  // Drives config and a one-cycle start; returns just after the accept edge
  // with inputs scrambled so a bad latch shows up in the frame.
  task automatic send(input logic [7:0] d, input logic db, input logic st,
                      input logic [1:0] pr, input logic [1:0] bd, input bit wait_rdy);
    if (wait_rdy) wait_ready();
    data_in_Tx = d; data_bit_sel = db; stop_sel = st; prty_sel = pr; bd_sel = bd;
    tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
    data_in_Tx = 8'($urandom); data_bit_sel = 1'($urandom); stop_sel = 1'($urandom);
    prty_sel = 2'($urandom); bd_sel = 2'($urandom);
  endtask

  // Samples mid-bit against a literal pattern, then measures accept-to-done.
  task automatic check_frame(input string name, input logic [11:0] seq,
                             input int nbits, input int bitlen);
    int el;
    step(bitlen / 2);
    el = bitlen / 2;
    for (int b = 0; b < nbits; b++) begin
      check($sformatf("%s_bit%0d", name, b), int'(data_out_Tx), int'(seq[b]));
      if (b < nbits - 1) begin step(bitlen); el += bitlen; end
    end
    while (!tx_done && el < nbits * bitlen + 100) begin step(1); el++; end
    check($sformatf("%s_done_latency", name), el, nbits * bitlen);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] seq;
    step(3);
    check("reset_line", int'(data_out_Tx), 1);
    check("reset_ready", int'(tx_ready), 1);
    check("reset_done", int'(tx_done), 0);
    chk_en = 1;
    rst = 1'b0;
    step(2);

    // 1200 baud, 7 bits, no parity, 1 stop
    send(8'b0000_1111, 1'b0, 1'b0, 2'b00, 2'b00, 1);
    seq = 12'h11E;
    check_frame("t1", seq, 9, 1536);

    // 9600 baud, 8 bits, even parity, 2 stop
    send(8'b0010_1010, 1'b1, 1'b1, 2'b10, 2'b11, 1);
    seq = 12'hE54;
    check_frame("t2", seq, 12, 192);

    // odd parity, four ones -> P=1, then P=0
    send(8'b1110_0001, 1'b1, 1'b1, 2'b01, 2'b11, 1);
    seq = 12'hFC2;
    check_frame("t3a", seq, 12, 192);
    send(8'b1110_0000, 1'b1, 1'b1, 2'b01, 2'b11, 1);
    seq = 12'hDC0;
    check_frame("t3b", seq, 12, 192);

    // start request mid-frame is ignored; start in done cycle is taken
    send(8'h3C, 1'b1, 1'b0, 2'b00, 2'b11, 1);
    step(300);
    data_in_Tx = 8'hFF; tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
    check("ignored_start_ready", int'(tx_ready), 0);
    wait_done();
    send(8'h96, 1'b1, 1'b0, 2'b10, 2'b11, 0);
    check("b2b_start_line", int'(data_out_Tx), 0);
    check("b2b_ready_low", int'(tx_ready), 0);

    // reset in the middle of data bit 3
    send(8'hA5, 1'b1, 1'b0, 2'b10, 2'b11, 1);
    step(4 * 192 + 96);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_line", int'(data_out_Tx), 1);
    check("rst_ready", int'(tx_ready), 1);
    check("rst_done", int'(tx_done), 0);
    step(50);
    send(8'b0010_1010, 1'b1, 1'b1, 2'b10, 2'b11, 1);
    seq = 12'hE54;
    check_frame("t5", seq, 12, 192);

    // randomized frames at the faster rates, checked by the model
    for (int unsigned r = 0; r < 8; r++) begin
      bit b2b;
      b2b = ($urandom_range(0, 2) == 0);
      if (b2b) begin
        wait_done();
      end else begin
        wait_ready();
        step($urandom_range(0, 20));
      end
      send(8'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
           2'($urandom_range(2, 3)), 0);
      step($urandom_range(10, 500));
      data_in_Tx = 8'($urandom); tx_start = 1'b1;
      step(1);
      tx_start = 1'b0;
    end
    wait_ready();
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
